// File: rtl/mem_packet_responder_if.sv
// mem_packet_responder_if
//   Packet bus between a unified cache and the memory responder.
//   The cache side uses the master modport; the memory side uses slave.
//   Signals:
//     to_mem_packet_in       request packet, cache -> memory
//     to_mem_packet_ack_out  one-cycle pulse, request consumed
//     from_mem_packet_out    read-return packet, memory -> cache
//     from_mem_packet_ack_in cache has taken the return packet
//   The packet layout macros below are shared by the whole cache family.
//   They are guarded so that whichever file is compiled first defines them.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS 4
`define UNIFIED_CACHE_PACKET_DATA_POS          0
`define UNIFIED_CACHE_PACKET_DATA_LEN          128
`define UNIFIED_CACHE_PACKET_ADDR_POS          128
`define UNIFIED_CACHE_PACKET_ADDR_LEN          32
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS     160
`define UNIFIED_CACHE_PACKET_BYTE_MASK_LEN     16
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS      176
`define UNIFIED_CACHE_PACKET_PORT_NUM_LEN      2
`define UNIFIED_CACHE_PACKET_TYPE_POS          178
`define UNIFIED_CACHE_PACKET_TYPE_LEN          2
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS     180
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS      181
`define UNIFIED_CACHE_PACKET_VALID_POS         182
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS     183
`endif

interface mem_packet_responder_if;
  logic [`UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_mem_packet_in;
  logic                                           to_mem_packet_ack_out;
  logic [`UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_mem_packet_out;
  logic                                           from_mem_packet_ack_in;

  modport master (
    output to_mem_packet_in,
    input  to_mem_packet_ack_out,
    input  from_mem_packet_out,
    output from_mem_packet_ack_in
  );

  modport slave (
    input  to_mem_packet_in,
    output to_mem_packet_ack_out,
    output from_mem_packet_out,
    input  from_mem_packet_ack_in
  );
endinterface

// File: rtl/mem_packet_responder.sv
// mem_packet_responder
//   Memory model behind a unified cache. Each request waits MEM_DELAY
//   cycles, is then captured, and either merges its data into one cache
//   block (write, byte-masked) or returns the block to the cache (read),
//   waiting up to TIMEOUT_CYCLE cycles for the return acknowledge.
//   Ports:
//     clk_in           rising-edge clock
//     reset_in         asynchronous, active-low reset
//     mem_bus          packet bus (slave side of mem_packet_responder_if)
//     busy_out         high whenever the FSM is not idle
//     error_out        sticky read-return timeout flag
//     read_count_out   serviced reads, saturating
//     write_count_out  serviced writes, saturating

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS 4
`define UNIFIED_CACHE_PACKET_DATA_POS          0
`define UNIFIED_CACHE_PACKET_DATA_LEN          128
`define UNIFIED_CACHE_PACKET_ADDR_POS          128
`define UNIFIED_CACHE_PACKET_ADDR_LEN          32
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS     160
`define UNIFIED_CACHE_PACKET_BYTE_MASK_LEN     16
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS      176
`define UNIFIED_CACHE_PACKET_PORT_NUM_LEN      2
`define UNIFIED_CACHE_PACKET_TYPE_POS          178
`define UNIFIED_CACHE_PACKET_TYPE_LEN          2
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS     180
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS      181
`define UNIFIED_CACHE_PACKET_VALID_POS         182
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS     183
`endif

module mem_packet_responder #(
  parameter int MEM_DEPTH     = 256,
  parameter int MEM_DELAY     = 10,
  parameter int TIMEOUT_CYCLE = 1000
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  mem_packet_responder_if.slave mem_bus,
  output logic                 busy_out,
  output logic                 error_out,
  output logic [15:0]          read_count_out,
  output logic [15:0]          write_count_out
);

  localparam int PW       = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int DATA_POS = `UNIFIED_CACHE_PACKET_DATA_POS;
  localparam int DATA_LEN = `UNIFIED_CACHE_PACKET_DATA_LEN;
  localparam int ADDR_POS = `UNIFIED_CACHE_PACKET_ADDR_POS;
  localparam int MASK_POS = `UNIFIED_CACHE_PACKET_BYTE_MASK_POS;
  localparam int MASK_LEN = `UNIFIED_CACHE_PACKET_BYTE_MASK_LEN;
  localparam int OFF_LEN  = `UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS;
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int DLY_W    = $clog2(MEM_DELAY + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLE + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DELAY       = 3'd1,
    WRITE       = 3'd2,
    READ_RETURN = 3'd3,
    FINAL       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   delay_cnt_q, delay_cnt_d;
  logic [TMO_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [PW-1:0]      req_q, req_d;
  logic [PW-1:0]      ret_pkt_q, ret_pkt_d;
  logic               ack_q, ack_d;
  logic               error_q, error_d;
  logic [15:0]        read_cnt_q, read_cnt_d;
  logic [15:0]        write_cnt_q, write_cnt_d;

  logic [DATA_LEN-1:0] mem [MEM_DEPTH];

  logic               req_valid;
  logic               req_is_write;
  logic [IDX_W-1:0]   idx_in;
  logic [IDX_W-1:0]   idx_q;
  logic [PW-1:0]      rd_pkt;
  logic [DATA_LEN-1:0] wr_data;
  logic               unused_req_bits;

  assign req_valid    = mem_bus.to_mem_packet_in[`UNIFIED_CACHE_PACKET_VALID_POS];
  assign req_is_write = mem_bus.to_mem_packet_in[`UNIFIED_CACHE_PACKET_IS_WRITE_POS];

  // Block index drops the byte offset and keeps only the low bits, so
  // out-of-range addresses alias silently onto the storage.
  assign idx_in = mem_bus.to_mem_packet_in[ADDR_POS + OFF_LEN +: IDX_W];
  assign idx_q  = req_q[ADDR_POS + OFF_LEN +: IDX_W];

  // The captured request is kept whole; only part of it feeds the write path.
  assign unused_req_bits = ^req_q;

  // Return packet is formed at capture time from the live request, which
  // is exactly what gets captured on the same edge.
  always_comb begin
    rd_pkt = mem_bus.to_mem_packet_in;
    rd_pkt[DATA_POS +: DATA_LEN] = mem[idx_in];
    rd_pkt[`UNIFIED_CACHE_PACKET_IS_WRITE_POS] = 1'b0;
    rd_pkt[`UNIFIED_CACHE_PACKET_VALID_POS]    = 1'b1;
  end

  // Byte-masked merge of the captured write data over the stored block.
  always_comb begin
    wr_data = mem[idx_q];
    for (int i = 0; i < MASK_LEN; i++) begin
      if (req_q[MASK_POS + i]) begin
        wr_data[8*i +: 8] = req_q[DATA_POS + 8*i +: 8];
      end
    end
  end

  // Next-state and registered-output logic for the whole transaction.
  always_comb begin
    state_d       = state_q;
    delay_cnt_d   = delay_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    req_d         = req_q;
    ret_pkt_d     = ret_pkt_q;
    ack_d         = 1'b0;
    error_d       = error_q;
    read_cnt_d    = read_cnt_q;
    write_cnt_d   = write_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = DELAY;
          delay_cnt_d = '0;
        end
      end
      DELAY: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else if (delay_cnt_q == DLY_W'(MEM_DELAY - 1)) begin
          req_d         = mem_bus.to_mem_packet_in;
          timeout_cnt_d = '0;
          if (req_is_write) begin
            state_d = WRITE;
          end else begin
            state_d   = READ_RETURN;
            ret_pkt_d = rd_pkt;
          end
        end else begin
          delay_cnt_d = delay_cnt_q + DLY_W'(1);
        end
      end
      WRITE: begin
        ack_d       = 1'b1;
        write_cnt_d = (write_cnt_q == 16'hFFFF) ? write_cnt_q : write_cnt_q + 16'd1;
        state_d     = FINAL;
      end
      READ_RETURN: begin
        if (mem_bus.from_mem_packet_ack_in) begin
          ret_pkt_d  = '0;
          ack_d      = 1'b1;
          read_cnt_d = (read_cnt_q == 16'hFFFF) ? read_cnt_q : read_cnt_q + 16'd1;
          state_d    = FINAL;
        end else if (timeout_cnt_q == TMO_W'(TIMEOUT_CYCLE - 1)) begin
          error_d   = 1'b1;
          ret_pkt_d = '0;
          ack_d     = 1'b1;
          state_d   = FINAL;
        end else begin
          timeout_cnt_d = timeout_cnt_q + TMO_W'(1);
        end
      end
      FINAL: begin
        ret_pkt_d = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= IDLE;
      delay_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      req_q         <= '0;
      ret_pkt_q     <= '0;
      ack_q         <= 1'b0;
      error_q       <= 1'b0;
      read_cnt_q    <= '0;
      write_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      delay_cnt_q   <= delay_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      req_q         <= req_d;
      ret_pkt_q     <= ret_pkt_d;
      ack_q         <= ack_d;
      error_q       <= error_d;
      read_cnt_q    <= read_cnt_d;
      write_cnt_q   <= write_cnt_d;
    end
  end

  // Storage keeps its contents across reset; a reset also leaves WRITE
  // unreachable for the interrupted transaction, so nothing is written.
  always_ff @(posedge clk_in) begin
    if (state_q == WRITE) begin
      mem[idx_q] <= wr_data;
    end
  end

  assign mem_bus.to_mem_packet_ack_out = ack_q;
  assign mem_bus.from_mem_packet_out   = ret_pkt_q;
  assign busy_out        = (state_q != IDLE);
  assign error_out       = error_q;
  assign read_count_out  = read_cnt_q;
  assign write_count_out = write_cnt_q;

endmodule

// File: tb/tb_mem_packet_responder.sv
// tb_mem_packet_responder
//   Directed bench for mem_packet_responder. A stimulus thread issues
//   requests and pushes the expected return packets and acknowledges into
//   queues; a monitor on the falling edge pops and compares them whenever
//   the DUT presents a return packet or an acknowledge pulse.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS 4
`define UNIFIED_CACHE_PACKET_DATA_POS          0
`define UNIFIED_CACHE_PACKET_DATA_LEN          128
`define UNIFIED_CACHE_PACKET_ADDR_POS          128
`define UNIFIED_CACHE_PACKET_ADDR_LEN          32
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS     160
`define UNIFIED_CACHE_PACKET_BYTE_MASK_LEN     16
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS      176
`define UNIFIED_CACHE_PACKET_PORT_NUM_LEN      2
`define UNIFIED_CACHE_PACKET_TYPE_POS          178
`define UNIFIED_CACHE_PACKET_TYPE_LEN          2
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS     180
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS      181
`define UNIFIED_CACHE_PACKET_VALID_POS         182
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS     183
`endif

module tb_mem_packet_responder;

  localparam int W             = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int VP            = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int MEM_DEPTH     = 256;
  localparam int MEM_DELAY     = 10;
  localparam int TIMEOUT_CYCLE = 20;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        busy_out;
  logic        error_out;
  logic [15:0] read_count_out;
  logic [15:0] write_count_out;

  mem_packet_responder_if bus();

  mem_packet_responder #(
    .MEM_DEPTH    (MEM_DEPTH),
    .MEM_DELAY    (MEM_DELAY),
    .TIMEOUT_CYCLE(TIMEOUT_CYCLE)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .mem_bus        (bus),
    .busy_out       (busy_out),
    .error_out      (error_out),
    .read_count_out (read_count_out),
    .write_count_out(write_count_out)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_ret_q[$];
  string        exp_ack_q[$];
  logic         prev_valid = 1'b0;
  logic         prev_ack   = 1'b0;
  logic [W-1:0] held_pkt   = '0;

  function automatic logic [W-1:0] make_pkt(
    input logic valid, input logic is_write, input logic [31:0] addr,
    input logic [127:0] data, input logic [15:0] mask, input logic [1:0] port,
    input logic [1:0] ptype, input logic cacheable);
    logic [W-1:0] p;
    p = '0;
    p[`UNIFIED_CACHE_PACKET_DATA_POS +: 128]    = data;
    p[`UNIFIED_CACHE_PACKET_ADDR_POS +: 32]     = addr;
    p[`UNIFIED_CACHE_PACKET_BYTE_MASK_POS +: 16] = mask;
    p[`UNIFIED_CACHE_PACKET_PORT_NUM_POS +: 2]  = port;
    p[`UNIFIED_CACHE_PACKET_TYPE_POS +: 2]      = ptype;
    p[`UNIFIED_CACHE_PACKET_CACHEABLE_POS]      = cacheable;
    p[`UNIFIED_CACHE_PACKET_IS_WRITE_POS]       = is_write;
    p[`UNIFIED_CACHE_PACKET_VALID_POS]          = valid;
    return p;
  endfunction

  // One comparison: count it, and report actual against required on a miss.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) until the DUT is back in IDLE, ending on a falling edge.
  task automatic waitIdle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk_in);
      if (!busy_out) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_idle: busy_out still 1 after 20 cycles, expected 0", name);
    end
  endtask

  // Issue one request from a falling edge and service the return side.
  // ret_wait < 0 never acknowledges the return packet; scramble rewrites
  // the request fields (keeping VALID) once the return packet is visible.
  task automatic applyStimulus(input string name, input logic [W-1:0] req,
                               input int ret_wait, input bit scramble,
                               output int ack_edge, output int valid_cycles);
    bit done;
    int seen;
    done         = 1'b0;
    seen         = 0;
    ack_edge     = -1;
    valid_cycles = 0;
    bus.to_mem_packet_in = req;
    for (int cyc = 0; cyc < MEM_DELAY + TIMEOUT_CYCLE + 50 && !done; cyc++) begin
      @(posedge clk_in);
      #1;
      if (bus.to_mem_packet_ack_out === 1'b1) begin
        ack_edge = cyc;
        done     = 1'b1;
      end else if (bus.from_mem_packet_out[VP] === 1'b1) begin
        valid_cycles++;
        seen++;
        if (scramble) bus.to_mem_packet_in = req ^ ~(W'(1) << VP);
        if (ret_wait >= 0 && seen > ret_wait) bus.from_mem_packet_ack_in = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_ack_timeout: no request ack seen, expected one", name);
    end
    bus.to_mem_packet_in       = '0;
    bus.from_mem_packet_ack_in = 1'b0;
    waitIdle(name);
  endtask

  // Monitor: pops the scoreboard on every ack pulse and on the first cycle
  // of each return packet; also checks pulse width and packet stability.
  always @(negedge clk_in) begin
    if (reset_in !== 1'b1) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (bus.to_mem_packet_ack_out === 1'b1) begin
        checkOutput("ack_pulse_width", W'(prev_ack), W'(0));
        checks++;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_ack: got ack, expected none");
        end else begin
          void'(exp_ack_q.pop_front());
        end
      end
      if (bus.from_mem_packet_out[VP] === 1'b1) begin
        if (!prev_valid) begin
          if (exp_ret_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_return: got %0h, expected none",
                     bus.from_mem_packet_out);
          end else begin
            checkOutput("return_packet", bus.from_mem_packet_out, exp_ret_q.pop_front());
          end
          held_pkt = bus.from_mem_packet_out;
        end else begin
          checkOutput("return_stable", bus.from_mem_packet_out, held_pkt);
        end
      end else begin
        checkOutput("return_idle_zero", bus.from_mem_packet_out, '0);
      end
      prev_valid = bus.from_mem_packet_out[VP];
      prev_ack   = bus.to_mem_packet_ack_out;
    end
  end

  // Global guard so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int vc;
    logic [127:0] alias_data;

    bus.to_mem_packet_in       = '0;
    bus.from_mem_packet_ack_in = 1'b0;
    reset_in = 1'b1;
    #1 reset_in = 1'b0;
    repeat (3) @(negedge clk_in);

    checkOutput("reset_busy",   W'(busy_out), W'(0));
    checkOutput("reset_error",  W'(error_out), W'(0));
    checkOutput("reset_rcount", W'(read_count_out), W'(0));
    checkOutput("reset_wcount", W'(write_count_out), W'(0));
    checkOutput("reset_ack",    W'(bus.to_mem_packet_ack_out), W'(0));
    checkOutput("reset_retpkt", bus.from_mem_packet_out, '0);

    reset_in = 1'b1;
    @(negedge clk_in);

    // Full write then read-back, with latency measured on both.
    exp_ack_q.push_back("wr_0x40");
    applyStimulus("wr_0x40", make_pkt(1, 1, 32'h40, {16{8'hAA}}, 16'hFFFF, 2'd2, 2'd1, 1'b1),
                  0, 1'b0, lat, vc);
    checkOutput("wr_latency", W'(lat), W'(MEM_DELAY + 1));

    exp_ret_q.push_back(make_pkt(1, 0, 32'h40, {16{8'hAA}}, 16'hFFFF, 2'd3, 2'd0, 1'b1));
    exp_ack_q.push_back("rd_0x40");
    applyStimulus("rd_0x40", make_pkt(1, 0, 32'h40, 128'h0, 16'hFFFF, 2'd3, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    checkOutput("rd_latency", W'(lat), W'(MEM_DELAY + 1));
    checkOutput("wcount_1", W'(write_count_out), W'(1));
    checkOutput("rcount_1", W'(read_count_out), W'(1));

    // Abort: VALID drops on DELAY cycle 3.
    bus.to_mem_packet_in = make_pkt(1, 1, 32'h40, {16{8'h55}}, 16'hFFFF, 2'd0, 2'd0, 1'b0);
    repeat (4) @(posedge clk_in);
    #1 bus.to_mem_packet_in = '0;
    repeat (MEM_DELAY + 4) @(negedge clk_in);
    checkOutput("abort_busy",   W'(busy_out), W'(0));
    checkOutput("abort_wcount", W'(write_count_out), W'(1));
    checkOutput("abort_rcount", W'(read_count_out), W'(1));

    // Read again with a late ack and a request changed after capture.
    exp_ret_q.push_back(make_pkt(1, 0, 32'h40, {16{8'hAA}}, 16'h0F0F, 2'd1, 2'd2, 1'b0));
    exp_ack_q.push_back("rd2_0x40");
    applyStimulus("rd2_0x40", make_pkt(1, 0, 32'h40, 128'h0, 16'h0F0F, 2'd1, 2'd2, 1'b0),
                  3, 1'b1, lat, vc);
    checkOutput("rd2_valid_cycles", W'(vc), W'(4));

    // Partial-mask merge.
    exp_ack_q.push_back("wr_0x80_a");
    applyStimulus("wr_0x80_a", make_pkt(1, 1, 32'h80, {16{8'h11}}, 16'hFFFF, 2'd0, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    exp_ack_q.push_back("wr_0x80_b");
    applyStimulus("wr_0x80_b", make_pkt(1, 1, 32'h80, {16{8'h22}}, 16'h000F, 2'd0, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    exp_ret_q.push_back(make_pkt(1, 0, 32'h80, {{12{8'h11}}, {4{8'h22}}}, 16'hFFFF, 2'd0, 2'd3, 1'b1));
    exp_ack_q.push_back("rd_0x80");
    applyStimulus("rd_0x80", make_pkt(1, 0, 32'h80, 128'h0, 16'hFFFF, 2'd0, 2'd3, 1'b1),
                  1, 1'b0, lat, vc);
    checkOutput("wcount_3", W'(write_count_out), W'(3));
    checkOutput("rcount_3", W'(read_count_out), W'(3));

    // Return never acknowledged: timeout path.
    exp_ret_q.push_back(make_pkt(1, 0, 32'h80, {{12{8'h11}}, {4{8'h22}}}, 16'h00FF, 2'd1, 2'd2, 1'b0));
    exp_ack_q.push_back("rd_timeout");
    applyStimulus("rd_timeout", make_pkt(1, 0, 32'h80, 128'h0, 16'h00FF, 2'd1, 2'd2, 1'b0),
                  -1, 1'b0, lat, vc);
    checkOutput("timeout_valid_cycles", W'(vc), W'(TIMEOUT_CYCLE));
    checkOutput("timeout_error", W'(error_out), W'(1));
    checkOutput("timeout_rcount", W'(read_count_out), W'(3));

    // Index MEM_DEPTH+5 aliases index 5 in both directions.
    alias_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_ack_q.push_back("wr_0x50");
    applyStimulus("wr_0x50", make_pkt(1, 1, 32'h50, alias_data, 16'hFFFF, 2'd0, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    exp_ret_q.push_back(make_pkt(1, 0, 32'h1050, alias_data, 16'hFFFF, 2'd2, 2'd0, 1'b1));
    exp_ack_q.push_back("rd_0x1050");
    applyStimulus("rd_0x1050", make_pkt(1, 0, 32'h1050, 128'h0, 16'hFFFF, 2'd2, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    exp_ack_q.push_back("wr_0x1050");
    applyStimulus("wr_0x1050", make_pkt(1, 1, 32'h1050, {16{8'hEE}}, 16'hF0F0, 2'd0, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    exp_ret_q.push_back(make_pkt(1, 0, 32'h50, 128'hEEEEEEEE_44556677_EEEEEEEE_CCDDEEFF,
                                 16'hFFFF, 2'd1, 2'd1, 1'b1));
    exp_ack_q.push_back("rd_0x50");
    applyStimulus("rd_0x50", make_pkt(1, 0, 32'h50, 128'h0, 16'hFFFF, 2'd1, 2'd1, 1'b1),
                  2, 1'b0, lat, vc);
    checkOutput("wcount_5", W'(write_count_out), W'(5));
    checkOutput("rcount_5", W'(read_count_out), W'(5));
    checkOutput("error_sticky", W'(error_out), W'(1));

    // Reset during DELAY: immediate idle, nothing written.
    bus.to_mem_packet_in = make_pkt(1, 1, 32'h40, {16{8'h77}}, 16'hFFFF, 2'd0, 2'd0, 1'b1);
    repeat (3) @(posedge clk_in);
    #2 reset_in = 1'b0;
    #1;
    checkOutput("midreset_busy",   W'(busy_out), W'(0));
    checkOutput("midreset_error",  W'(error_out), W'(0));
    checkOutput("midreset_wcount", W'(write_count_out), W'(0));
    checkOutput("midreset_rcount", W'(read_count_out), W'(0));
    bus.to_mem_packet_in = '0;
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);

    exp_ret_q.push_back(make_pkt(1, 0, 32'h40, {16{8'hAA}}, 16'hFFFF, 2'd0, 2'd0, 1'b1));
    exp_ack_q.push_back("rd_after_reset");
    applyStimulus("rd_after_reset", make_pkt(1, 0, 32'h40, 128'h0, 16'hFFFF, 2'd0, 2'd0, 1'b1),
                  0, 1'b0, lat, vc);
    checkOutput("post_reset_rcount", W'(read_count_out), W'(1));
    checkOutput("post_reset_wcount", W'(write_count_out), W'(0));

    repeat (3) @(negedge clk_in);
    checkOutput("ret_queue_empty", W'(exp_ret_q.size()), W'(0));
    checkOutput("ack_queue_empty", W'(exp_ack_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
